m_pkt_fifo: RTL and testbench

- Store-and-forward packet FIFO directly downstream of the `m` packet matcher; consumes its `out_vld_r`/`out_r` word stream, which is 8B words tagged with sop/eop/length/buffer.
- A packet becomes visible at egress only after its EOP word is written. Partial packets are never emitted.
- Upstream has no backpressure. When a packet cannot be held entirely, the whole packet is dropped and counted.
- Egress is valid/ready toward the buffer-writer stage.

---
 rtl/m_pkg.sv | 27 ++
 rtl/m_pkt_fifo_if.sv | 27 ++
 rtl/m_pkt_fifo_ram.sv | 28 ++
 rtl/m_pkt_fifo.sv | 198 +++++++++++++++++++
 tb/tb_m_pkt_fifo.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_pkg.sv
// Shared types for the m packet matcher and its downstream packet FIFO.
// m_pkt_fifo honours optional macro M_PKT_FIFO_BUF_FILTER_EN (see m_pkt_fifo.sv).
package m_pkg;

    localparam int unsigned M_PKT_FIFO_DEPTH_W = 4;
    localparam int unsigned M_LEN_W            = 4;
    localparam int unsigned M_BUF_W            = 4;

    typedef logic [M_BUF_W-1:0] buffer_t;
    typedef logic [M_LEN_W-1:0] length_t;

    // Matcher output word: {sop, eop, length, data[63:0], buffer}
    typedef struct packed {
        logic        sop;
        logic        eop;
        length_t     length;
        logic [63:0] data;
        buffer_t     buffer;
    } out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } m_pkt_fifo_state_t;

endpackage

// File: rtl/m_pkt_fifo_if.sv
// Ingress word stream plus egress valid/ready handshake of m_pkt_fifo.
interface m_pkt_fifo_if;
    import m_pkg::*;

    logic in_vld;
    out_t in;
    logic out_vld;
    out_t out;
    logic out_rdy;

    modport master (
        output in_vld,
        output in,
        input  out_vld,
        input  out,
        output out_rdy
    );

    modport slave (
        input  in_vld,
        input  in,
        output out_vld,
        output out,
        input  out_rdy
    );

endinterface

// File: rtl/m_pkt_fifo_ram.sv
// Word storage for m_pkt_fifo: flop array, one sync write port, one async read port, no reset.
module m_pkt_fifo_ram
    import m_pkg::*;
#(
    parameter int unsigned DEPTH_W = M_PKT_FIFO_DEPTH_W
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [DEPTH_W-1:0] i_waddr,
    input  out_t               i_wdata,
    input  logic [DEPTH_W-1:0] i_raddr,
    output out_t               o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    out_t r_mem [DEPTH];

    // Write port: contents are only meaningful below the write pointer
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/m_pkt_fifo.sv
// Store-and-forward packet FIFO behind the m matcher. Packets become visible
// only once their EOP word is stored; packets that cannot fit are dropped whole.
// Optional macro M_PKT_FIFO_BUF_FILTER_EN: silently discard packets whose EOP
// buffer is zero and count them on stat_filt_cnt_r.
module m_pkt_fifo
    import m_pkg::*;
#(
    parameter int unsigned DEPTH_W = M_PKT_FIFO_DEPTH_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    m_pkt_fifo_if.slave        bus,
    output logic [CNT_W-1:0]   stat_drop_cnt_r,
    output logic [DEPTH_W:0]   stat_occ_r
`ifdef M_PKT_FIFO_BUF_FILTER_EN
    ,
    output logic [CNT_W-1:0]   stat_filt_cnt_r
`endif
);

    localparam logic [DEPTH_W:0] PTR_DEPTH = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] PTR_ONE   = {{DEPTH_W{1'b0}}, 1'b1};

    m_pkt_fifo_state_t r_state;
    m_pkt_fifo_state_t w_state_nxt;

    logic [DEPTH_W:0]   r_wr_ptr;
    logic [DEPTH_W:0]   r_cm_ptr;
    logic [DEPTH_W:0]   r_rd_ptr;
    logic [DEPTH_W:0]   w_wr_nxt;
    logic [DEPTH_W:0]   w_cm_nxt;
    logic [DEPTH_W:0]   w_rd_nxt;
    logic [DEPTH_W-1:0] w_wr_addr;
    logic               w_wr_en;
    logic               w_eop_acc;
    logic [1:0]         w_drop_inc;
    logic               w_full_wr;
    logic               w_full_cm;
    logic               w_empty;
    logic               w_out_vld;
    logic               w_rd_fire;
    logic               w_filt_hit;
    logic [CNT_W:0]     w_drop_sum;
    out_t               w_rd_data;

    logic [CNT_W-1:0]   r_drop_cnt;
    logic [DEPTH_W:0]   r_occ;

    m_pkt_fifo_ram #(
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (bus.in),
        .i_raddr (r_rd_ptr[DEPTH_W-1:0]),
        .o_rdata (w_rd_data)
    );

    // Full for continuing a packet counts uncommitted words; full for a new
    // SOP is judged after discarding any unfinished packet (wr_ptr == cm_ptr).
    assign w_full_wr = (r_wr_ptr - r_rd_ptr) == PTR_DEPTH;
    assign w_full_cm = (r_cm_ptr - r_rd_ptr) == PTR_DEPTH;
    assign w_empty   = (r_rd_ptr == r_cm_ptr);
    assign w_out_vld = !w_empty;
    assign w_rd_fire = w_out_vld && bus.out_rdy;
    assign w_rd_nxt  = w_rd_fire ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    assign bus.out_vld = w_out_vld;
    assign bus.out     = w_rd_data;

`ifdef M_PKT_FIFO_BUF_FILTER_EN
    logic             w_filt_inc;
    logic [CNT_W:0]   w_filt_sum;
    logic [CNT_W-1:0] r_filt_cnt;
    assign w_filt_hit = (bus.in.buffer == '0);
`else
    assign w_filt_hit = 1'b0;
`endif

    // Write FSM: next state, write strobe, pointer updates, drop/filter events
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_wr_ptr[DEPTH_W-1:0];
        w_wr_nxt    = r_wr_ptr;
        w_cm_nxt    = r_cm_ptr;
        w_drop_inc  = 2'd0;
        w_eop_acc   = 1'b0;
`ifdef M_PKT_FIFO_BUF_FILTER_EN
        w_filt_inc  = 1'b0;
`endif
        if (bus.in_vld) begin
            if (bus.in.sop) begin
                // A SOP in any state restarts from the commit point; an open
                // packet is abandoned first, so two drops can land in one cycle.
                if (r_state == WRITE) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_wr_nxt   = r_cm_ptr;
                end
                if (w_full_cm) begin
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = bus.in.eop ? IDLE : DROP;
                end else begin
                    w_wr_en     = 1'b1;
                    w_wr_addr   = r_cm_ptr[DEPTH_W-1:0];
                    w_wr_nxt    = r_cm_ptr + PTR_ONE;
                    w_eop_acc   = bus.in.eop;
                    w_state_nxt = bus.in.eop ? IDLE : WRITE;
                end
            end else begin
                case (r_state)
                    WRITE: begin
                        if (w_full_wr) begin
                            w_wr_nxt    = r_cm_ptr;
                            w_drop_inc  = 2'd1;
                            w_state_nxt = bus.in.eop ? IDLE : DROP;
                        end else begin
                            w_wr_en   = 1'b1;
                            w_wr_nxt  = r_wr_ptr + PTR_ONE;
                            w_eop_acc = bus.in.eop;
                            if (bus.in.eop) begin
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (bus.in.eop) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // Completing a packet either commits it or, when filtered, rewinds
        // without writing the EOP word.
        if (w_eop_acc) begin
            if (w_filt_hit) begin
                w_wr_en  = 1'b0;
                w_wr_nxt = r_cm_ptr;
`ifdef M_PKT_FIFO_BUF_FILTER_EN
                w_filt_inc = 1'b1;
`endif
            end else begin
                w_cm_nxt = w_wr_nxt;
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_inc);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, saturating drop counter and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
            r_occ      <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_cm_ptr   <= w_cm_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
            r_occ      <= w_wr_nxt - w_rd_nxt;
        end
    end

    assign stat_drop_cnt_r = r_drop_cnt;
    assign stat_occ_r      = r_occ;

`ifdef M_PKT_FIFO_BUF_FILTER_EN
    assign w_filt_sum = {1'b0, r_filt_cnt} + {{CNT_W{1'b0}}, w_filt_inc};

    // Saturating count of packets discarded by the buffer filter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= w_filt_sum[CNT_W] ? '1 : w_filt_sum[CNT_W-1:0];
        end
    end

    assign stat_filt_cnt_r = r_filt_cnt;
`endif

endmodule

// File: tb/tb_m_pkt_fifo.sv
// Scoreboard bench for m_pkt_fifo: packet-level reference model feeds an
// expected-word queue; a negedge monitor checks egress and statistics.
module tb_m_pkt_fifo;
    import m_pkg::*;

    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] drop_cnt;
    logic [DW:0] occ;
`ifdef M_PKT_FIFO_BUF_FILTER_EN
    logic [15:0] filt_cnt;
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    m_pkt_fifo_if bus ();

    m_pkt_fifo #(
        .DEPTH_W (DW),
        .CNT_W   (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .stat_drop_cnt_r (drop_cnt),
        .stat_occ_r      (occ)
`ifdef M_PKT_FIFO_BUF_FILTER_EN
        ,
        .stat_filt_cnt_r (filt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model: committed-but-unread words, open packet, drop mode
    out_t sb[$];
    out_t cur[$];
    int   avail    = 0;
    int   m_drops  = 0;
    int   m_filt   = 0;
    bit   in_pkt   = 1'b0;
    bit   dropping = 1'b0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic out_t mk(bit sop, bit eop, logic [63:0] data, buffer_t b);
        out_t w;
        w.sop    = sop;
        w.eop    = eop;
        w.length = length_t'($urandom_range(1, 15));
        w.data   = data;
        w.buffer = b;
        return w;
    endfunction

    function automatic void finish_pkt(out_t w);
        if (FILT && w.buffer == '0) begin
            m_filt++;
        end else begin
            foreach (cur[i]) sb.push_back(cur[i]);
            avail += cur.size();
        end
        cur.delete();
        in_pkt = 1'b0;
    endfunction

    // Effect of one clock edge, judged on the occupancy before that edge
    function automatic void model_step(bit v, out_t w, bit rdy);
        int pre_avail;
        pre_avail = avail;
        if (v) begin
            if (w.sop) begin
                if (in_pkt) begin
                    m_drops++;
                    cur.delete();
                end
                in_pkt   = 1'b0;
                dropping = 1'b0;
                if (pre_avail >= DEPTH) begin
                    m_drops++;
                    dropping = !w.eop;
                end else begin
                    cur.push_back(w);
                    if (w.eop) finish_pkt(w);
                    else in_pkt = 1'b1;
                end
            end else if (in_pkt) begin
                if (pre_avail + cur.size() >= DEPTH) begin
                    m_drops++;
                    cur.delete();
                    in_pkt   = 1'b0;
                    dropping = !w.eop;
                end else begin
                    cur.push_back(w);
                    if (w.eop) finish_pkt(w);
                end
            end else if (dropping && w.eop) begin
                dropping = 1'b0;
            end
        end
        if (m_drops > 65535) m_drops = 65535;
        if (rdy && pre_avail > 0) avail--;
    endfunction

    task automatic cycle(bit v, out_t w, bit rdy);
        bus.in_vld  = v;
        bus.in      = w;
        bus.out_rdy = rdy;
        @(posedge clk);
        #1;
        model_step(v, w, rdy);
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
    endtask

    task automatic send_pkt(int n, bit with_eop, buffer_t b, bit rdy);
        for (int i = 0; i < n; i++)
            cycle(1'b1, mk(i == 0, with_eop && (i == n - 1), {$urandom, $urandom}, b), rdy);
    endtask

    // Monitor: egress handshake against scoreboard, statistics against model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_vld", longint'(bus.out_vld), longint'(avail > 0));
            if (bus.out_vld && bus.out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL egress_extra: got word %h expected none", bus.out);
                end else begin
                    out_t exp;
                    exp = sb.pop_front();
                    if (bus.out !== exp) begin
                        failures++;
                        $display("FAIL egress_word: got %h expected %h", bus.out, exp);
                    end
                end
            end
            chk("stat_occ", longint'(occ), longint'(avail + cur.size()));
            chk("stat_drop", longint'(drop_cnt), longint'(m_drops));
`ifdef M_PKT_FIFO_BUF_FILTER_EN
            chk("stat_filt", longint'(filt_cnt), longint'(m_filt));
`endif
        end
    end

    task automatic model_clear();
        sb.delete();
        cur.delete();
        avail    = 0;
        m_drops  = 0;
        m_filt   = 0;
        in_pkt   = 1'b0;
        dropping = 1'b0;
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_out_vld"}, longint'(bus.out_vld), 0);
        chk({tag, "_drop"}, longint'(drop_cnt), 0);
        chk({tag, "_occ"}, longint'(occ), 0);
`ifdef M_PKT_FIFO_BUF_FILTER_EN
        chk({tag, "_filt"}, longint'(filt_cnt), 0);
`endif
    endtask

    initial begin
        out_t w;
        rst         = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in      = '0;
        bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single-word packet, fall-through latency
        cycle(1'b1, mk(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, buffer_t'(5)), 1'b1);
        idle(3, 1'b1);

        // Three-word packet, invisible until EOP stored
        for (int i = 1; i <= 3; i++)
            cycle(1'b1, mk(i == 1, i == 3, 64'(i), buffer_t'(3)), 1'b1);
        idle(5, 1'b1);

        // Fill to capacity with egress stalled, then overflow packet
        for (int p = 0; p < 4; p++) send_pkt(4, 1'b1, buffer_t'(p + 1), 1'b0);
        send_pkt(2, 1'b1, buffer_t'(7), 1'b0);
        idle(2, 1'b0);
        idle(20, 1'b1);

        // Packet longer than capacity, then a normal one
        send_pkt(17, 1'b1, buffer_t'(2), 1'b1);
        send_pkt(2, 1'b1, buffer_t'(4), 1'b1);
        idle(4, 1'b1);

        // Missing EOP, stray continuation word, zero-buffer single word
        send_pkt(2, 1'b0, buffer_t'(6), 1'b1);
        cycle(1'b1, mk(1'b1, 1'b1, 64'hB1, buffer_t'(9)), 1'b1);
        cycle(1'b1, mk(1'b0, 1'b1, 64'hDEAD, buffer_t'(9)), 1'b1);
        cycle(1'b1, mk(1'b1, 1'b1, 64'hB2, buffer_t'(0)), 1'b1);
        send_pkt(3, 1'b1, buffer_t'(0), 1'b1);
        idle(4, 1'b1);

        // Asynchronous reset mid-packet with a word waiting at egress
        send_pkt(1, 1'b1, buffer_t'(1), 1'b0);
        send_pkt(2, 1'b0, buffer_t'(1), 1'b0);
        #3;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_reset_state("async_rst");
        bus.in_vld = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        send_pkt(1, 1'b1, buffer_t'(8), 1'b1);
        idle(3, 1'b1);

        // Randomized traffic with varying egress pressure
        for (int blk = 0; blk < 40; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int k = 0; k < 8; k++) begin
                int act;
                act = $urandom_range(0, 9);
                if (act < 2) begin
                    cycle(1'b0, '0, $urandom_range(0, 99) < rdy_pct);
                end else if (act == 2) begin
                    w = mk(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom}, buffer_t'($urandom));
                    cycle(1'b1, w, $urandom_range(0, 99) < rdy_pct);
                end else begin
                    int  n;
                    bit  eop_ok;
                    buffer_t b;
                    n      = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 20) : $urandom_range(1, 6);
                    eop_ok = $urandom_range(0, 7) != 0;
                    b      = ($urandom_range(0, 3) == 0) ? buffer_t'(0) : buffer_t'($urandom_range(1, 15));
                    for (int i = 0; i < n; i++) begin
                        if ($urandom_range(0, 5) == 0) cycle(1'b0, '0, $urandom_range(0, 99) < rdy_pct);
                        cycle(1'b1, mk(i == 0, eop_ok && (i == n - 1), {$urandom, $urandom}, b),
                              $urandom_range(0, 99) < rdy_pct);
                    end
                end
            end
        end

        idle(40, 1'b1);
        chk("drained", longint'(bus.out_vld), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
